// File: rtl/app_switcher_pkg.sv
// Shared types and constants for the app_switcher foreground controller.
//   state_t   : controller states (MENU, RUN, ALERT)
//   MENU_TAG  : nibble shown above the selection index on the menu screen
//   KEY_*     : bit positions of the six keys inside the internal key vectors
package app_switcher_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALERT = 2'd2
    } state_t;

    localparam logic [3:0] MENU_TAG = 4'hF;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;
    localparam int KEY_ESC   = 5;
    localparam int N_KEYS    = 6;

endpackage

// File: rtl/app_switcher_key_gate.sv
// key_gate: per-key edge detector and swallow mask.
//   clk, rst : clock and synchronous active-high reset
//   key      : raw key level (already synchronised)
//   consume  : controller uses this key's current rising edge
//   enable   : keys may be forwarded to the apps (controller in RUN)
//   rise     : key went high this cycle
//   btn      : gated key level seen by the apps
module key_gate (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic consume,
    input  logic enable,
    output logic rise,
    output logic btn
);

    logic key_q_reg;
    logic mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q_reg <= 1'b0;
            mask_reg  <= 1'b0;
        end else begin
            key_q_reg <= key;
            // A consumed press stays hidden until the key is released.
            if (consume)
                mask_reg <= 1'b1;
            else if (!key)
                mask_reg <= 1'b0;
        end
    end

    assign rise = key & ~key_q_reg;
    // consume also blanks the edge cycle itself, before the mask is set.
    assign btn  = key & ~mask_reg & ~consume & enable;

endmodule

// File: rtl/app_switcher.sv
// app_switcher: foreground controller for the shared keypad and display.
//   clk, rst          : clock, synchronous active-high reset
//   key_*             : raw synchronised key levels
//   app_norm[N_APP]   : 1 = app idle, 0 = app in its own edit mode
//   app_alert[N_APP]  : per-app preemption request (level)
//   app_disp          : N_APP display words, app i at [i*DISP_W +: DISP_W]
//   app_mode[N_APP]   : one-hot foreground select, zero in MENU
//   btn_*             : gated key levels to the apps
//   alert_ack[N_APP]  : one-cycle acknowledge of a user-dismissed alert
//   disp_out          : display word (menu word or foreground app word)
//   menu_sel          : current menu selection index
module app_switcher
    import app_switcher_pkg::*;
#(
    parameter int N_APP  = 4,
    parameter int DISP_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_up,
    input  logic                    key_down,
    input  logic                    key_left,
    input  logic                    key_right,
    input  logic                    key_enter,
    input  logic                    key_esc,
    input  logic [N_APP-1:0]        app_norm,
    input  logic [N_APP-1:0]        app_alert,
    input  logic [N_APP*DISP_W-1:0] app_disp,
    output logic [N_APP-1:0]        app_mode,
    output logic                    btn_up,
    output logic                    btn_down,
    output logic                    btn_left,
    output logic                    btn_right,
    output logic                    btn_enter,
    output logic                    btn_esc,
    output logic [N_APP-1:0]        alert_ack,
    output logic [DISP_W-1:0]       disp_out,
    output logic [3:0]              menu_sel
);

    localparam logic [N_APP-1:0] ONE      = {{(N_APP-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LAST_SEL = 4'(N_APP - 1);

    state_t              state_reg;
    state_t              saved_reg;
    logic [3:0]          menu_sel_reg;
    logic [3:0]          alert_idx_reg;
    logic [N_APP-1:0]    app_mode_reg;
    logic [N_APP-1:0]    alert_ack_reg;
    logic [N_APP-1:0]    alert_q_reg;
    logic [DISP_W-1:0]   disp_reg;

    logic [N_KEYS-1:0]   key_vec;
    logic [N_KEYS-1:0]   rise;
    logic [N_KEYS-1:0]   consume;
    logic [N_KEYS-1:0]   btn_vec;
    logic [N_APP-1:0]    alert_rise;
    logic [3:0]          low_idx;
    logic [3:0]          fg_idx;
    logic                sel_norm;
    logic                alert_held;
    logic [N_APP-1:0]    restore_mode;
    logic [DISP_W-1:0]   fg_word;
    logic [DISP_W-1:0]   menu_word;
    logic [DISP_W-1:0]   app_words [N_APP];

    assign key_vec[KEY_UP]    = key_up;
    assign key_vec[KEY_DOWN]  = key_down;
    assign key_vec[KEY_LEFT]  = key_left;
    assign key_vec[KEY_RIGHT] = key_right;
    assign key_vec[KEY_ENTER] = key_enter;
    assign key_vec[KEY_ESC]   = key_esc;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_gate u_key_gate (
                .clk     (clk),
                .rst     (rst),
                .key     (key_vec[gi]),
                .consume (consume[gi]),
                .enable  (state_reg == ST_RUN),
                .rise    (rise[gi]),
                .btn     (btn_vec[gi])
            );
        end
        for (gi = 0; gi < N_APP; gi++) begin : g_word
            assign app_words[gi] = app_disp[gi*DISP_W +: DISP_W];
        end
    endgenerate

    assign alert_rise   = app_alert & ~alert_q_reg;
    assign alert_held   = |(app_alert & (ONE << alert_idx_reg));
    assign restore_mode = (saved_reg == ST_RUN) ? (ONE << menu_sel_reg) : '0;
    assign fg_idx       = (state_reg == ST_ALERT) ? alert_idx_reg : menu_sel_reg;
    assign menu_word    = {{(DISP_W-8){1'b0}}, MENU_TAG, menu_sel_reg};

    always_comb begin
        // Lowest-index rising alert wins: scan downwards so index 0 lands last.
        low_idx = '0;
        for (int i = N_APP - 1; i >= 0; i--)
            if (alert_rise[i]) low_idx = 4'(i);

        sel_norm = 1'b0;
        fg_word  = '0;
        for (int i = 0; i < N_APP; i++) begin
            if (menu_sel_reg == 4'(i)) sel_norm = app_norm[i];
            if (fg_idx == 4'(i))       fg_word  = app_words[i];
        end

        // Which key edges the controller uses this cycle.
        consume = '0;
        if (state_reg != ST_RUN || (|alert_rise))
            consume = rise;
        else
            consume[KEY_ESC] = rise[KEY_ESC] & sel_norm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_MENU;
            saved_reg     <= ST_MENU;
            menu_sel_reg  <= '0;
            alert_idx_reg <= '0;
            app_mode_reg  <= '0;
            alert_ack_reg <= '0;
            alert_q_reg   <= '0;
            disp_reg      <= {{(DISP_W-8){1'b0}}, MENU_TAG, 4'd0};
        end else begin
            alert_q_reg   <= app_alert;
            alert_ack_reg <= '0;
            disp_reg      <= (state_reg == ST_MENU) ? menu_word : fg_word;

            case (state_reg)
                ST_MENU, ST_RUN: begin
                    if (|alert_rise) begin
                        saved_reg     <= state_reg;
                        state_reg     <= ST_ALERT;
                        alert_idx_reg <= low_idx;
                        app_mode_reg  <= ONE << low_idx;
                    end else if (state_reg == ST_MENU) begin
                        if (rise[KEY_ENTER]) begin
                            state_reg    <= ST_RUN;
                            app_mode_reg <= ONE << menu_sel_reg;
                        end else if (rise[KEY_LEFT]) begin
                            menu_sel_reg <= (menu_sel_reg == 4'd0) ? LAST_SEL
                                                                    : menu_sel_reg - 4'd1;
                        end else if (rise[KEY_RIGHT]) begin
                            menu_sel_reg <= (menu_sel_reg == LAST_SEL) ? 4'd0
                                                                        : menu_sel_reg + 4'd1;
                        end
                    end else if (rise[KEY_ESC] && sel_norm) begin
                        state_reg    <= ST_MENU;
                        app_mode_reg <= '0;
                    end
                end
                ST_ALERT: begin
                    if (|rise) begin
                        alert_ack_reg <= ONE << alert_idx_reg;
                        state_reg     <= saved_reg;
                        app_mode_reg  <= restore_mode;
                    end else if (!alert_held) begin
                        state_reg     <= saved_reg;
                        app_mode_reg  <= restore_mode;
                    end
                end
                default: begin
                    state_reg    <= ST_MENU;
                    app_mode_reg <= '0;
                end
            endcase
        end
    end

    assign app_mode  = app_mode_reg;
    assign alert_ack = alert_ack_reg;
    assign disp_out  = disp_reg;
    assign menu_sel  = menu_sel_reg;

    assign btn_up    = btn_vec[KEY_UP];
    assign btn_down  = btn_vec[KEY_DOWN];
    assign btn_left  = btn_vec[KEY_LEFT];
    assign btn_right = btn_vec[KEY_RIGHT];
    assign btn_enter = btn_vec[KEY_ENTER];
    assign btn_esc   = btn_vec[KEY_ESC];

endmodule

// File: tb/tb_app_switcher.sv
// Self-checking bench for app_switcher: directed scenarios plus a randomized
// run compared against a behavioural model of the controller.
module tb_app_switcher;

    localparam int N_APP  = 4;
    localparam int DISP_W = 48;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [5:0]              keys = '0;   // up, down, left, right, enter, esc
    logic [N_APP-1:0]        app_norm = '1;
    logic [N_APP-1:0]        app_alert = '0;
    logic [N_APP*DISP_W-1:0] app_disp;
    logic [N_APP-1:0]        app_mode;
    logic [N_APP-1:0]        alert_ack;
    logic [DISP_W-1:0]       disp_out;
    logic [3:0]              menu_sel;
    logic                    btn_up, btn_down, btn_left, btn_right, btn_enter, btn_esc;
    logic [5:0]              btn_vec;
    logic [DISP_W-1:0]       words [N_APP];

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 = menu, 1 = running an app, 2 = alert shown.
    int         m_mode, m_saved, m_sel, m_aidx;
    logic [5:0] m_used, m_prev;
    logic [3:0] m_aprev, m_ack;
    logic [47:0] m_disp;

    always #5 clk = ~clk;

    assign btn_vec = {btn_esc, btn_enter, btn_right, btn_left, btn_down, btn_up};

    app_switcher #(.N_APP(N_APP), .DISP_W(DISP_W)) dut (
        .clk(clk), .rst(rst),
        .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]),
        .key_right(keys[3]), .key_enter(keys[4]), .key_esc(keys[5]),
        .app_norm(app_norm), .app_alert(app_alert), .app_disp(app_disp),
        .app_mode(app_mode),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_enter(btn_enter), .btn_esc(btn_esc),
        .alert_ack(alert_ack), .disp_out(disp_out), .menu_sel(menu_sel)
    );

    function automatic logic [47:0] menu_word(input int sel);
        logic [47:0] w;
        w = 48'h0;
        w[7:4] = 4'hF;
        w[3:0] = 4'(sel);
        return w;
    endfunction

    function automatic logic [5:0] model_consume();
        logic [5:0] r;
        logic [3:0] ar;
        r  = keys & ~m_prev;
        ar = app_alert & ~m_aprev;
        if (m_mode != 1 || ar != 0) return r;
        if (r[5] && app_norm[m_sel]) return 6'b100000;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] model_btn();
        if (m_mode != 1) return 6'b0;
        return keys & ~m_used & ~model_consume();
    endfunction

    function automatic logic [3:0] model_mode();
        if (m_mode == 0) return 4'b0000;
        if (m_mode == 1) return 4'(1 << m_sel);
        return 4'(1 << m_aidx);
    endfunction

    task automatic model_update();
        logic [5:0] r, cons;
        logic [3:0] ar;
        int old;
        if (rst) begin
            m_mode = 0; m_saved = 0; m_sel = 0; m_aidx = 0;
            m_used = 0; m_prev = 0; m_aprev = 0; m_ack = 0;
            m_disp = menu_word(0);
            return;
        end
        r    = keys & ~m_prev;
        ar   = app_alert & ~m_aprev;
        cons = model_consume();
        m_disp = (m_mode == 0) ? menu_word(m_sel) : words[(m_mode == 2) ? m_aidx : m_sel];
        m_ack = 0;
        old = m_mode;
        if (old != 2 && ar != 0) begin
            m_saved = old;
            for (int i = N_APP - 1; i >= 0; i--) if (ar[i]) m_aidx = i;
            m_mode = 2;
        end else if (old == 0) begin
            if (r[4]) m_mode = 1;
            else if (r[2]) m_sel = (m_sel + N_APP - 1) % N_APP;
            else if (r[3]) m_sel = (m_sel + 1) % N_APP;
        end else if (old == 1) begin
            if (r[5] && app_norm[m_sel]) m_mode = 0;
        end else begin
            if (r != 0) begin
                m_ack = 4'(1 << m_aidx);
                m_mode = m_saved;
            end else if (!app_alert[m_aidx]) begin
                m_mode = m_saved;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (cons[k]) m_used[k] = 1'b1;
            else if (!keys[k]) m_used[k] = 1'b0;
        end
        m_prev  = keys;
        m_aprev = app_alert;
    endtask

    // Advance one clock: model follows the DUT edge, back at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; keys = '0; app_alert = '0; app_norm = '1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (app_mode !== 4'b0000) begin errors++; $display("FAIL reset_mode got %b want 0000", app_mode); end
        checks++; if (menu_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", menu_sel); end
        checks++; if (alert_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", alert_ack); end
        checks++; if (btn_vec !== 6'b0) begin errors++; $display("FAIL reset_btn got %b want 000000", btn_vec); end
        checks++; if (disp_out !== 48'h0000_0000_00F0) begin errors++; $display("FAIL reset_disp got %h want 0000000000f0", disp_out); end
        $display("test_reset: mode=%b sel=%0d disp=%h", app_mode, menu_sel, disp_out);
    endtask

    task automatic test_menu_wrap();
        keys = 6'b000100; tick(); keys = '0;
        checks++; if (menu_sel !== 4'd3) begin errors++; $display("FAIL wrap_left got %0d want 3", menu_sel); end
        tick();
        checks++; if (disp_out[7:0] !== 8'hF3) begin errors++; $display("FAIL wrap_disp got %h want f3", disp_out[7:0]); end
        $display("test_menu_wrap: left -> sel=%0d disp=%h", menu_sel, disp_out[7:0]);
        for (int i = 0; i < 2; i++) begin
            keys = 6'b001000; tick(); keys = '0; tick();
        end
        checks++; if (menu_sel !== 4'd1) begin errors++; $display("FAIL wrap_right got %0d want 1", menu_sel); end
        $display("test_menu_wrap: right x2 -> sel=%0d", menu_sel);
    endtask

    task automatic test_launch();
        keys = 6'b010000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (btn_enter !== 1'b0) begin errors++; $display("FAIL launch_mask cycle %0d got %b want 0", i, btn_enter); end
            tick();
            if (i == 0) begin
                checks++; if (app_mode !== 4'b0010) begin errors++; $display("FAIL launch_mode got %b want 0010", app_mode); end
            end
        end
        keys = '0; tick();
        keys = 6'b010000; #1;
        checks++; if (btn_enter !== 1'b1) begin errors++; $display("FAIL launch_second got %b want 1", btn_enter); end
        tick(); keys = '0; tick();
        $display("test_launch: mode=%b second enter forwarded", app_mode);
    endtask

    task automatic test_esc_idle();
        app_norm = 4'b1111;
        keys = 6'b100000; #1;
        checks++; if (btn_esc !== 1'b0) begin errors++; $display("FAIL esc_idle_btn got %b want 0", btn_esc); end
        tick();
        checks++; if (app_mode !== 4'b0000) begin errors++; $display("FAIL esc_idle_mode got %b want 0000", app_mode); end
        #1;
        checks++; if (btn_esc !== 1'b0) begin errors++; $display("FAIL esc_idle_held got %b want 0", btn_esc); end
        keys = '0; tick();
        $display("test_esc_idle: mode=%b sel=%0d", app_mode, menu_sel);
    endtask

    task automatic test_esc_edit();
        keys = 6'b010000; tick(); keys = '0; tick();
        app_norm = 4'b1101;
        keys = 6'b100000; #1;
        checks++; if (btn_esc !== 1'b1) begin errors++; $display("FAIL esc_edit_btn got %b want 1", btn_esc); end
        tick();
        checks++; if (app_mode !== 4'b0010) begin errors++; $display("FAIL esc_edit_mode got %b want 0010", app_mode); end
        app_norm = 4'b1111; #1;
        checks++; if (btn_esc !== 1'b1) begin errors++; $display("FAIL esc_edit_held got %b want 1", btn_esc); end
        tick(); tick();
        checks++; if (app_mode !== 4'b0010) begin errors++; $display("FAIL esc_edit_stay got %b want 0010", app_mode); end
        keys = '0; tick();
        $display("test_esc_edit: mode=%b after held esc", app_mode);
    endtask

    task automatic test_alert_ack();
        keys = 6'b100000; tick(); keys = '0; tick();          // back to menu
        keys = 6'b000100; tick(); keys = '0; tick();          // sel 0
        keys = 6'b010000; tick(); keys = '0; tick();          // run app 0
        checks++; if (app_mode !== 4'b0001) begin errors++; $display("FAIL alert_run got %b want 0001", app_mode); end
        app_alert = 4'b1010; tick();
        checks++; if (app_mode !== 4'b0010) begin errors++; $display("FAIL alert_mode got %b want 0010", app_mode); end
        tick();
        checks++; if (disp_out !== words[1]) begin errors++; $display("FAIL alert_disp got %h want %h", disp_out, words[1]); end
        keys = 6'b000001; #1;
        checks++; if (btn_up !== 1'b0) begin errors++; $display("FAIL alert_btn got %b want 0", btn_up); end
        tick();
        checks++; if (alert_ack !== 4'b0010) begin errors++; $display("FAIL alert_ack got %b want 0010", alert_ack); end
        checks++; if (app_mode !== 4'b0001) begin errors++; $display("FAIL alert_restore got %b want 0001", app_mode); end
        keys = '0; tick();
        checks++; if (alert_ack !== 4'b0000) begin errors++; $display("FAIL alert_ack_pulse got %b want 0000", alert_ack); end
        app_alert = '0; tick();
        $display("test_alert_ack: restored mode=%b", app_mode);
    endtask

    task automatic test_alert_tie_reset();
        keys = 6'b100000; tick(); keys = '0; tick();          // to menu
        keys = 6'b010000; app_alert = 4'b0100; tick();
        checks++; if (app_mode !== 4'b0100) begin errors++; $display("FAIL tie_mode got %b want 0100", app_mode); end
        keys = '0; tick();
        checks++; if (app_mode !== 4'b0100) begin errors++; $display("FAIL tie_hold got %b want 0100", app_mode); end
        rst = 1'b1; tick();
        checks++; if (app_mode !== 4'b0000) begin errors++; $display("FAIL tie_rst_mode got %b want 0000", app_mode); end
        checks++; if (menu_sel !== 4'd0) begin errors++; $display("FAIL tie_rst_sel got %0d want 0", menu_sel); end
        checks++; if (alert_ack !== 4'b0000) begin errors++; $display("FAIL tie_rst_ack got %b want 0000", alert_ack); end
        checks++; if (disp_out !== 48'h0000_0000_00F0) begin errors++; $display("FAIL tie_rst_disp got %h want 0000000000f0", disp_out); end
        app_alert = '0; tick(); rst = 1'b0; tick();
        $display("test_alert_tie_reset: mode=%b sel=%0d", app_mode, menu_sel);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 6; k++)
                if ($urandom_range(5) == 0) keys[k] = ~keys[k];
            for (int a = 0; a < N_APP; a++)
                if ($urandom_range(11) == 0) app_alert[a] = ~app_alert[a];
            if ($urandom_range(7) == 0) app_norm = 4'($urandom);
            rst = ($urandom_range(149) == 0);
            #1;
            if (!rst) begin
                checks++;
                if (btn_vec !== model_btn()) begin errors++; $display("FAIL rnd_btn cycle %0d got %b want %b", c, btn_vec, model_btn()); end
            end
            tick();
            checks++;
            if (app_mode !== model_mode()) begin errors++; $display("FAIL rnd_mode cycle %0d got %b want %b", c, app_mode, model_mode()); end
            checks++;
            if (menu_sel !== 4'(m_sel)) begin errors++; $display("FAIL rnd_sel cycle %0d got %0d want %0d", c, menu_sel, m_sel); end
            checks++;
            if (alert_ack !== m_ack) begin errors++; $display("FAIL rnd_ack cycle %0d got %b want %b", c, alert_ack, m_ack); end
            checks++;
            if (disp_out !== m_disp) begin errors++; $display("FAIL rnd_disp cycle %0d got %h want %h", c, disp_out, m_disp); end
            $display("rnd %0d: keys=%b alert=%b mode=%b sel=%0d ack=%b", c, keys, app_alert, app_mode, menu_sel, alert_ack);
        end
        rst = 1'b0; keys = '0; app_alert = '0;
    endtask

    initial begin
        for (int i = 0; i < N_APP; i++) begin
            words[i] = {16'($urandom), 32'($urandom)};
            app_disp[i*DISP_W +: DISP_W] = words[i];
        end
        @(negedge clk);
        test_reset();
        test_menu_wrap();
        test_launch();
        test_esc_idle();
        test_esc_edit();
        test_alert_ack();
        test_alert_tie_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
